pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline-stage register, the successor to the fixed-width MEM/WB latch. It is intended for any inter-stage boundary (IF/ID through MEM/WB).
- Carries a control field, NWORDS data words and a destination-register index.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is fully registered.
- Adds flush (bubble insertion), write-control squashing on empty output, and a saturating stall counter.

Parameters:
- CTL_W, 2, width of the control field (e.g. WB controls).
- DATA_W, 32, width of each data word.
- NWORDS, 2, number of data words carried (e.g. mem read data and ALU result).
- REG_W, 5, width of the destination register index.
- SQUASH_CTL, 1, when 1, o_ctl is forced to 0 while out_valid=0.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered.
- i_ctl  in  CTL_W  control field.
- i_data  in  NWORDS*DATA_W  data words; word k occupies bits [k*DATA_W +: DATA_W].
- i_reg  in  REG_W  destination register index.
- out_valid  out  1  output payload valid.
- out_ready  in  1  downstream accepts.
- o_ctl  out  CTL_W  control field.
- o_data  out  NWORDS*DATA_W  data words.
- o_reg  out  REG_W  destination register index.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturating.
- clr_cnt  in  1  synchronous clear of stall_cnt.

Behaviour:
- Storage: main entry (drives outputs) and skid entry; each holds payload plus a valid bit.
- State: EMPTY (neither entry valid), ONE (main only), TWO (main+skid). Skid is never valid without main.
- Handshakes: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- out_valid = main valid. in_ready = registered !skid_valid, i.e. 1 in EMPTY/ONE, 0 in TWO.
- Transitions:
  - EMPTY: in_xfer -> ONE, payload loaded into main.
  - ONE, in_xfer & !out_xfer -> TWO, payload into skid.
  - ONE, in_xfer & out_xfer -> ONE, main replaced by input.
  - ONE, !in_xfer & out_xfer -> EMPTY.
  - ONE, otherwise hold.
  - TWO, out_xfer -> ONE, skid moves to main and skid is cleared.
  - TWO, otherwise hold. in_xfer is impossible because in_ready=0.
- Latency: 1 cycle from in_xfer to out_valid when the stage is EMPTY. Sustained throughput is 1 per cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, o_ctl, o_data and o_reg hold constant.
- Flush:
  - Next state is EMPTY; main and skid valid bits are cleared.
  - in_xfer in the same cycle is discarded.
  - in_ready becomes 1 in the next cycle.
  - Flush has priority over every transition.
- Squash: when SQUASH_CTL=1 and out_valid=0, o_ctl=0, so downstream register-write enables are never asserted by a bubble. o_data and o_reg keep their last value (don't-care).
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt has priority over increment; the counter reads 0 in the following cycle.
  - Flush does not clear it.
- Reset (asynchronous assert, synchronous deassert assumed from top):
  - State EMPTY; both valid bits 0; out_valid=0; in_ready=1.
  - o_ctl, o_data, o_reg = 0; stall_cnt=0.
  - Reset mid-transfer drops both entries with no output handshake.
- Payload width: CTL_W + NWORDS*DATA_W + REG_W. No arithmetic on payload. NWORDS>=1 required; elaboration error otherwise.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding typedef: EMPTY=2'b00, ONE=2'b01, TWO=2'b11;
  - default widths WORD_W=32, REGIDX_W=5, WBCTL_W=2;
  - payload-width helper function.
- One natural sub-module: sat_counter (CNT_W parameter; inc, clr), reused for perf counters elsewhere.
- The skid datapath stays inline.

Test Plan:
- Reset then single transfer: rstn 0->1; in_valid=1, i_ctl=2'b11, i_data={32'hDEADBEEF, 32'h00000010}, i_reg=5'd7, out_ready=1 -> out_valid=1 next cycle with identical payload, in_ready stays 1.
- Back-to-back stream: 8 beats with i_data words = 0..7, out_ready=1 -> 8 consecutive output beats in order, no bubbles, stall_cnt=0.
- Backpressure fill: out_ready=0 during 3 input attempts A, B, C:
  - A is accepted into main, B into skid, then in_ready=0 and C is held upstream;
  - stall_cnt=2 after the two stall cycles;
  - after out_ready=1, the output sequence is A, B, C.
- Flush in TWO: main and skid full, assert flush with in_valid=1 -> next cycle out_valid=0, o_ctl=0 (SQUASH_CTL=1), in_ready=1, and the input beat is not delivered.
- Counter saturation: CNT_W=4, out_ready=0 with a valid held for 20 cycles -> stall_cnt reaches 15 and stays there; clr_cnt pulse -> 0 next cycle.
- Async reset mid-operation: in TWO with payload held, drop rstn between clock edges -> out_valid=0, o_ctl/o_data/o_reg=0, in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared skid-stage state encoding, default widths and payload sizing
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b11} skid_state_e;
  localparam int WORD_W = 32;
  localparam int REGIDX_W = 5;
  localparam int WBCTL_W = 2;
  function automatic int payload_w(input int ctl_w, input int data_w, input int nwords, input int reg_w);
    return ctl_w + nwords * data_w + reg_w;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic pipeline register with a 2-entry skid buffer,
// flush, bubble control squashing and a saturating stall counter
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTL_W      = WBCTL_W,
  parameter int DATA_W     = WORD_W,
  parameter int NWORDS     = 2,
  parameter int REG_W      = REGIDX_W,
  parameter int SQUASH_CTL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTL_W-1:0]         i_ctl,
  input  logic [NWORDS*DATA_W-1:0] i_data,
  input  logic [REG_W-1:0]         i_reg,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTL_W-1:0]         o_ctl,
  output logic [NWORDS*DATA_W-1:0] o_data,
  output logic [REG_W-1:0]         o_reg,
  output logic [CNT_W-1:0]         stall_cnt,
  input  logic                     clr_cnt
);
  localparam int PW = payload_w(CTL_W, DATA_W, NWORDS, REG_W);
  if (NWORDS < 1) begin : g_bad_nwords
    $error("pipe_skid_stage: NWORDS must be at least 1");
  end
  skid_state_e   state_q, state_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;
  logic          in_ready_q, in_ready_d, in_xfer, out_xfer;
  assign in_pl     = {i_ctl, i_data, i_reg};
  assign out_valid = state_q != EMPTY;
  assign in_ready  = in_ready_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_xfer) begin
        state_d = ONE;
        main_d  = in_pl;
      end
      ONE: if (in_xfer && !out_xfer) begin
        state_d = TWO;
        skid_d  = in_pl;
      end else if (in_xfer) main_d = in_pl;
      else if (out_xfer) state_d = EMPTY;
      TWO: if (out_xfer) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // flush only kills the valid bits; held payload becomes don't-care
    if (flush) state_d = EMPTY;
    in_ready_d = state_d != TWO;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  assign o_ctl  = (SQUASH_CTL != 0 && !out_valid) ? '0 : main_q[PW-1 -: CTL_W];
  assign o_data = main_q[REG_W +: NWORDS*DATA_W];
  assign o_reg  = main_q[REG_W-1:0];
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rstn(rstn),
    .inc (out_valid & ~out_ready),
    .clr (clr_cnt),
    .cnt (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: randomized and directed scoreboard bench for pipe_skid_stage
module tb_pipe_skid_stage;
  localparam int PW = 71;
  typedef logic [PW-1:0] pl_t;
  logic        clk = 0, rstn = 0, flush = 0, in_valid = 0, out_ready = 0, clr_cnt = 0;
  logic        in_ready, out_valid;
  logic [1:0]  i_ctl = 0, o_ctl;
  logic [63:0] i_data = 0, o_data;
  logic [4:0]  i_reg = 0, o_reg;
  logic [3:0]  stall_cnt;
  int          checks = 0, errors = 0;
  pl_t         q[$];
  int          exp_cnt = 0;

  pipe_skid_stage #(.CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .i_ctl(i_ctl), .i_data(i_data), .i_reg(i_reg), .out_valid(out_valid), .out_ready(out_ready),
    .o_ctl(o_ctl), .o_data(o_data), .o_reg(o_reg), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [63:0] d, input logic [4:0] r);
    in_valid = 1;
    i_ctl = c;
    i_data = d;
    i_reg = r;
  endtask

  task automatic wait_accept(input string name);
    logic acc;
    for (int k = 0; k < 20; k++) begin
      acc = in_ready;
      step();
      if (acc) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  // reference model: the stage is a FIFO of at most two beats, sampled mid-cycle
  always @(negedge clk) begin
    int sz;
    if (!rstn) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      sz = q.size();
      chk("out_valid", out_valid, sz != 0);
      chk("in_ready", in_ready, sz < 2);
      chk("stall_cnt", stall_cnt, exp_cnt);
      if (sz == 0) chk("o_ctl_squash", o_ctl, 0);
      else chk("payload", {o_ctl, o_data, o_reg}, q[0]);
      if (clr_cnt) exp_cnt = 0;
      else if (sz != 0 && !out_ready) exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      if (sz != 0 && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && sz < 2) q.push_back({i_ctl, i_data, i_reg});
    end
  end

  initial begin
    repeat (2) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {o_ctl, o_data, o_reg}, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rstn = 1;
    out_ready = 1;
    drive(2'b11, {32'hDEADBEEF, 32'h00000010}, 5'd7);
    step();
    in_valid = 0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_payload", {o_ctl, o_data, o_reg}, {2'b11, 32'hDEADBEEF, 32'h00000010, 5'd7});
    step();
    for (int i = 0; i < 8; i++) begin
      drive(i[1:0], {i[31:0], i[31:0]}, i[4:0]);
      step();
    end
    in_valid = 0;
    repeat (3) step();
    chk("t2_stall_cnt", stall_cnt, 0);
    out_ready = 0;
    clr_cnt = 1;
    step();
    clr_cnt = 0;
    drive(2'b01, 64'hA, 5'd1);
    step();
    drive(2'b10, 64'hB, 5'd2);
    step();
    drive(2'b11, 64'hC, 5'd3);
    step();
    chk("t3_stall_cnt", stall_cnt, 2);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_main_is_a", o_data, 64'hA);
    out_ready = 1;
    wait_accept("t3_c");
    in_valid = 0;
    repeat (4) step();
    out_ready = 0;
    drive(2'b11, 64'h1111, 5'd4);
    step();
    drive(2'b11, 64'h2222, 5'd5);
    step();
    chk("t4_full", in_ready, 0);
    drive(2'b11, 64'h3333, 5'd6);
    flush = 1;
    step();
    flush = 0;
    in_valid = 0;
    chk("t4_out_valid", out_valid, 0);
    chk("t4_o_ctl", o_ctl, 0);
    chk("t4_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (3) step();
    chk("t4_no_delivery", out_valid, 0);
    out_ready = 0;
    clr_cnt = 1;
    step();
    clr_cnt = 0;
    drive(2'b10, 64'h5A5A, 5'd9);
    step();
    in_valid = 0;
    repeat (20) step();
    chk("t5_saturated", stall_cnt, 15);
    step();
    chk("t5_held", stall_cnt, 15);
    clr_cnt = 1;
    step();
    clr_cnt = 0;
    chk("t5_cleared", stall_cnt, 0);
    drive(2'b01, 64'h7777, 5'd10);
    step();
    in_valid = 0;
    chk("t6_two", in_ready, 0);
    #2 rstn = 0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_outputs", {o_ctl, o_data, o_reg}, 0);
    chk("t6_stall_cnt", stall_cnt, 0);
    step();
    rstn = 1;
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 1);
      i_ctl = 2'($urandom);
      i_data = {$urandom, $urandom};
      i_reg = 5'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      clr_cnt = $urandom_range(0, 24) == 0;
      step();
    end
    in_valid = 0;
    flush = 0;
    clr_cnt = 0;
    out_ready = 1;
    repeat (4) step();
    chk("drain_empty", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
